// File: rtl/reg_bank_writeback.sv
// 32 x 32-bit register bank with registered read ports, same-edge write bypass
// and a one-cycle write-commit strobe for the writeback stage.
module reg_bank_writeback #(
  parameter logic [31:0] SP_RESET = 32'd227
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [4:0]  last_write_reg,
  output logic        write_valid
);

  localparam int NumRegs = 32;
  localparam int SpIdx   = 29;

  logic [31:0] regs_q [NumRegs];
  logic [31:0] regs_d [NumRegs];
  logic [31:0] read_data1_q, read_data1_d;
  logic [31:0] read_data2_q, read_data2_d;
  logic [4:0]  last_write_reg_q, last_write_reg_d;
  logic        write_valid_q, write_valid_d;
  logic        write_commit;

  always_comb begin
    write_commit = reg_write && (write_reg != 5'd0);

    regs_d = regs_q;
    if (write_commit) begin
      regs_d[write_reg] = write_data;
    end

    // Index 0 is forced to zero here so a discarded write to 0 can never leak through.
    if (read_reg1 == 5'd0) begin
      read_data1_d = '0;
    end else if (write_commit && (write_reg == read_reg1)) begin
      read_data1_d = write_data;
    end else begin
      read_data1_d = regs_q[read_reg1];
    end

    if (read_reg2 == 5'd0) begin
      read_data2_d = '0;
    end else if (write_commit && (write_reg == read_reg2)) begin
      read_data2_d = write_data;
    end else begin
      read_data2_d = regs_q[read_reg2];
    end

    write_valid_d    = write_commit;
    last_write_reg_d = write_commit ? write_reg : last_write_reg_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= (i == SpIdx) ? SP_RESET : '0;
      end
      read_data1_q     <= '0;
      read_data2_q     <= '0;
      last_write_reg_q <= '0;
      write_valid_q    <= 1'b0;
    end else begin
      regs_q           <= regs_d;
      read_data1_q     <= read_data1_d;
      read_data2_q     <= read_data2_d;
      last_write_reg_q <= last_write_reg_d;
      write_valid_q    <= write_valid_d;
    end
  end

  assign read_data1     = read_data1_q;
  assign read_data2     = read_data2_q;
  assign last_write_reg = last_write_reg_q;
  assign write_valid    = write_valid_q;

endmodule

// File: tb/tb_reg_bank_writeback.sv
// Scoreboard bench for reg_bank_writeback: a behavioural register model queues the
// expected outputs of each edge, which are popped and compared just after that edge.
module tb_reg_bank_writeback;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [4:0]  last_write_reg;
  logic        write_valid;

  reg_bank_writeback #(
    .SP_RESET (32'd227)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .reg_write      (reg_write),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .read_reg1      (read_reg1),
    .read_reg2      (read_reg2),
    .read_data1     (read_data1),
    .read_data2     (read_data2),
    .last_write_reg (last_write_reg),
    .write_valid    (write_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wv;
    logic [4:0]  lwr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_regs [32];
  logic [4:0]  m_lwr;
  int          n_vec;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one edge's inputs, queue the model's prediction, then compare after the edge.
  task automatic step(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic rst_n);
    exp_t e;
    logic commit;
    reset      = rst_n;
    reg_write  = rw;
    write_reg  = wr;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
    if (!rst_n) begin
      e = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'd227 : 32'd0;
      m_lwr = 5'd0;
    end else begin
      commit = rw && (wr != 5'd0);
      e.rd1  = (r1 == 5'd0) ? 32'd0 : (commit && wr == r1) ? wd : m_regs[r1];
      e.rd2  = (r2 == 5'd0) ? 32'd0 : (commit && wr == r2) ? wd : m_regs[r2];
      e.wv   = commit;
      if (commit) begin
        m_regs[wr] = wd;
        m_lwr      = wr;
      end
      e.lwr = m_lwr;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("read_data1", read_data1, e.rd1);
    check("read_data2", read_data2, e.rd2);
    check("write_valid", {31'd0, write_valid}, {31'd0, e.wv});
    check("last_write_reg", {27'd0, last_write_reg}, {27'd0, e.lwr});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_lwr = 5'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    reset = 1'b0; reg_write = 1'b0; write_reg = 5'd0; write_data = 32'd0;
    read_reg1 = 5'd0; read_reg2 = 5'd0;

    step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 5'd29, 5'd0, 1'b1);
    check("sp_reset_value", read_data1, 32'd227);

    step(1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1);
    check("wv_after_write", {31'd0, write_valid}, 32'd1);
    check("lwr_after_write", {27'd0, last_write_reg}, 32'd8);
    step(1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 1'b1);
    check("readback_r8", read_data1, 32'hDEADBEEF);

    step(1'b1, 5'd31, 32'h00400010, 5'd31, 5'd31, 1'b1);
    check("bypass_port2", read_data2, 32'h00400010);

    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1);
    check("r0_lwr_held", {27'd0, last_write_reg}, 32'd31);

    step(1'b1, 5'd9, 32'd1, 5'd0, 5'd0, 1'b1);
    step(1'b1, 5'd10, 32'd2, 5'd9, 5'd0, 1'b1);
    step(1'b1, 5'd11, 32'd3, 5'd10, 5'd9, 1'b1);
    check("b2b_lwr_11", {27'd0, last_write_reg}, 32'd11);
    step(1'b0, 5'd0, 32'd0, 5'd11, 5'd10, 1'b1);
    check("b2b_r11", read_data1, 32'd3);

    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
           5'($urandom), 5'($urandom), ($urandom_range(0, 39) != 0));
    end

    step(1'b1, 5'd29, 32'd5, 5'd0, 5'd0, 1'b1);
    step(1'b1, 5'd29, 32'd7, 5'd29, 5'd29, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 5'd0, 32'd0, 5'(i), 5'(i + 16), 1'b1);
    end
    step(1'b0, 5'd0, 32'd0, 5'd29, 5'd1, 1'b1);
    check("sp_after_reset", read_data1, 32'd227);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
